// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: MEM/WB write-data select codes and register-file addressing.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_PC   = 2'b10,
    MTR_RSVD = 2'b11
  } mtr_e;

  localparam int REG_ZERO   = 0;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select: ALU result, load data or link address; the reserved code yields 0.
module wb_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        memtoreg_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] pc_next_i,
  output logic [DATA_W-1:0] wb_data_o
);

  always_comb begin
    wb_data_o = '0;
    case (memtoreg_i)
      MTR_ALU: wb_data_o = alu_result_i;
      MTR_MEM: wb_data_o = read_data_i;
      MTR_PC:  wb_data_o = pc_next_i;
      default: wb_data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Two-read / one-write architectural register file fed by the MEM/WB stage.
// Define REGFILE_BYPASS_EN for write-first reads of the register being written.
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  WB_RegWr,
  input  logic [1:0]            WB_MemtoReg,
  input  logic [REG_ADDR_W-1:0] WB_WriteAddr,
  input  logic [DATA_W-1:0]     WB_ReadData,
  input  logic [DATA_W-1:0]     WB_ALU_result,
  input  logic [DATA_W-1:0]     WB_PC_next,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]     rs_data,
  output logic [DATA_W-1:0]     rt_data,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  wb_valid
);

  logic [REG_NUM-1:0][DATA_W-1:0] regs;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .memtoreg_i   (WB_MemtoReg),
    .read_data_i  (WB_ReadData),
    .alu_result_i (WB_ALU_result),
    .pc_next_i    (WB_PC_next),
    .wb_data_o    (wb_data)
  );

  assign wb_valid = WB_RegWr
                 && (WB_WriteAddr != REG_ADDR_W'(REG_ZERO))
                 && (WB_MemtoReg != MTR_RSVD);

  // One flop bank per register; r0 is hardwired so writes to it vanish.
  for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
    if (r == REG_ZERO) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] rf_q, rf_d;

      always_comb begin
        rf_d = rf_q;
        if (wb_valid && (WB_WriteAddr == REG_ADDR_W'(r))) rf_d = wb_data;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rf_q <= '0;
        else          rf_q <= rf_d;
      end

      assign regs[r] = rf_q;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (32'(rs_addr) < REG_NUM) rs_data = regs[rs_addr];
    if (32'(rt_addr) < REG_NUM) rt_data = regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first: the committing value wins over the stale stored copy.
    if (wb_valid && (rs_addr == WB_WriteAddr)) rs_data = wb_data;
    if (wb_valid && (rt_addr == WB_WriteAddr)) rt_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expected reads come from a reference register model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        WB_RegWr;
  logic [1:0]  WB_MemtoReg;
  logic [4:0]  WB_WriteAddr;
  logic [31:0] WB_ReadData, WB_ALU_result, WB_PC_next;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_valid;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [32];
  logic [31:0] exp_q [$];
  logic [31:0] e;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset_n(reset_n), .WB_RegWr(WB_RegWr), .WB_MemtoReg(WB_MemtoReg),
    .WB_WriteAddr(WB_WriteAddr), .WB_ReadData(WB_ReadData), .WB_ALU_result(WB_ALU_result),
    .WB_PC_next(WB_PC_next), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_valid(wb_valid)
  );

  function automatic logic [31:0] m_wbdata();
    case (WB_MemtoReg)
      2'b00:   return WB_ALU_result;
      2'b01:   return WB_ReadData;
      2'b10:   return WB_PC_next;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_valid();
    return WB_RegWr && (WB_WriteAddr != 5'd0) && (WB_MemtoReg != 2'b11);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (reset_n && m_valid() && a == WB_WriteAddr) return m_wbdata();
`endif
    return mdl[a];
  endfunction

  // Push the model's view of both read ports for the current inputs.
  task automatic push_reads();
    exp_q.push_back(m_read(rs_addr));
    exp_q.push_back(m_read(rt_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n && m_valid()) mdl[WB_WriteAddr] = m_wbdata();
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] mtr, input logic [4:0] wa,
                       input logic [31:0] val, input logic [4:0] rs, input logic [4:0] rt);
    WB_RegWr = we; WB_MemtoReg = mtr; WB_WriteAddr = wa;
    WB_ALU_result = val; WB_ReadData = val ^ 32'h0F0F_0000; WB_PC_next = val + 32'd4;
    if (mtr == 2'b01) WB_ReadData = val;
    if (mtr == 2'b10) WB_PC_next = val;
    rs_addr = rs; rt_addr = rt;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd1, 5'd31);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e) begin fails++; $display("FAIL rst_init_rs got %h want %h", rs_data, e); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e) begin fails++; $display("FAIL rst_init_rt got %h want %h", rt_data, e); end
    @(negedge clk); reset_n = 1'b1;
    drive(1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
    tick();
    drive(1'b0, 2'b00, 5'd5, 32'h0, 5'd5, 5'd5);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'hDEAD_BEEF) begin fails++; $display("FAIL pre_rst_r5 got %h want %h", rs_data, 32'hDEAD_BEEF); end
    void'(exp_q.pop_front());
    // Mid-cycle reset pulse, with a write pending into r6.
    drive(1'b1, 2'b01, 5'd6, 32'h1357_9BDF, 5'd5, 5'd6);
    reset_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #1;
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h0) begin fails++; $display("FAIL rst_async_r5 got %h want %h", rs_data, 32'h0); end
    void'(exp_q.pop_front());
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1357_9BDF) begin
      fails++; $display("FAIL rst_wb_comb got %b/%h want 1/%h", wb_valid, wb_data, 32'h1357_9BDF);
    end
    tick();
    @(negedge clk); reset_n = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd6, 5'd5);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h0) begin fails++; $display("FAIL rst_blocked_r6 got %h want %h", rs_data, 32'h0); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_write_read();
    drive(1'b1, 2'b01, 5'd8, 32'h1234_5678, 5'd8, 5'd9);
    tests++;
    if (wb_data !== 32'h1234_5678 || wb_valid !== 1'b1) begin
      fails++; $display("FAIL wr_wb got %b/%h want 1/%h", wb_valid, wb_data, 32'h1234_5678);
    end
    tick();
    drive(1'b0, 2'b01, 5'd8, 32'h0, 5'd8, 5'd9);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h1234_5678) begin fails++; $display("FAIL wr_rs8 got %h want %h", rs_data, 32'h1234_5678); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e || e !== 32'h0) begin fails++; $display("FAIL wr_rt9 got %h want %h", rt_data, 32'h0); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    tests++;
    if (wb_valid !== 1'b0) begin fails++; $display("FAIL zero_valid got %b want 0", wb_valid); end
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 5'd8);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h0) begin fails++; $display("FAIL zero_r0 got %h want %h", rs_data, 32'h0); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e) begin fails++; $display("FAIL zero_r8 got %h want %h", rt_data, e); end
  endtask

  task automatic test_link_rsvd();
    drive(1'b1, 2'b10, 5'd31, 32'h0040_0010, 5'd31, 5'd8);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd31, 5'd8);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h0040_0010) begin fails++; $display("FAIL link_r31 got %h want %h", rs_data, 32'h0040_0010); end
    void'(exp_q.pop_front());
    drive(1'b1, 2'b11, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd8);
    tests++;
    if (wb_data !== 32'h0 || wb_valid !== 1'b0) begin
      fails++; $display("FAIL rsvd_wb got %b/%h want 0/0", wb_valid, wb_data);
    end
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 5'd31, 5'd8);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'h0040_0010) begin fails++; $display("FAIL rsvd_r31 got %h want %h", rs_data, 32'h0040_0010); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e || e !== 32'h1234_5678) begin fails++; $display("FAIL rsvd_r8 got %h want %h", rt_data, 32'h1234_5678); end
  endtask

  task automatic test_bypass();
    logic [31:0] same;
    drive(1'b1, 2'b00, 5'd3, 32'h1, 5'd3, 5'd3);
    tick();
    drive(1'b1, 2'b00, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
    same = 32'hA5A5_A5A5;
`else
    same = 32'h1;
`endif
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== same) begin fails++; $display("FAIL byp_same_rs got %h want %h", rs_data, same); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e || rt_data !== rs_data) begin fails++; $display("FAIL byp_same_rt got %h want %h", rt_data, same); end
    tick();
    drive(1'b0, 2'b00, 5'd3, 32'h0, 5'd3, 5'd3);
    push_reads();
    e = exp_q.pop_front(); tests++;
    if (rs_data !== e || e !== 32'hA5A5_A5A5) begin fails++; $display("FAIL byp_next_rs got %h want %h", rs_data, 32'hA5A5_A5A5); end
    e = exp_q.pop_front(); tests++;
    if (rt_data !== e) begin fails++; $display("FAIL byp_next_rt got %h want %h", rt_data, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ew;
    logic        ev;
    for (int n = 0; n < 60; n++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (n % 4 == 0) rs_addr = WB_WriteAddr;
      #1;
      ew = m_wbdata(); ev = m_valid();
      push_reads();
      tests++;
      if (wb_data !== ew || wb_valid !== ev) begin
        fails++; $display("FAIL b2b_wb[%0d] got %b/%h want %b/%h", n, wb_valid, wb_data, ev, ew);
      end
      e = exp_q.pop_front(); tests++;
      if (rs_data !== e) begin fails++; $display("FAIL b2b_rs[%0d] a=%0d got %h want %h", n, rs_addr, rs_data, e); end
      e = exp_q.pop_front(); tests++;
      if (rt_data !== e) begin fails++; $display("FAIL b2b_rt[%0d] a=%0d got %h want %h", n, rt_addr, rt_data, e); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_link_rsvd();
    test_bypass();
    test_back_to_back();
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL sb_drain got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
